snake_tick_gen: RTL and testbench

Programmable game-tick generator for the snake game. Divides `vga_clk` into a single-cycle `tick` whose period shortens by a fixed step per speed level, saturating at a minimum period. Adds pause, synchronous restart, a mid-period `half_tick` for animation, and a wrapping tick counter. Sits between the top-level control and the snake movement/collision logic, which advances one step per `tick`.

---
 rtl/snake_tick_gen.sv | 132 +++++++++++++
 tb/tb_snake_tick_gen.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_tick_gen.sv
// snake_tick_gen
//
// Game-tick generator for the snake game. Divides vga_clk into a one-cycle
// tick whose period shrinks by STEP cycles per speed level, bottoming out at
// MIN_PERIOD. Also produces a mid-period half_tick for animation, a wrapping
// count of ticks, and the current level/period for the rest of the game.
//
// Ports
//   vga_clk    in   clock (25 MHz)
//   sys_rst    in   synchronous active-high reset
//   en         in   1 = run, 0 = pause (interval counter frozen)
//   restart    in   synchronous soft clear, same effect as sys_rst
//   level_up   in   single-cycle request to raise the speed level by one
//   tick       out  one-cycle pulse at the end of every period
//   half_tick  out  one-cycle pulse at mid-period
//   level      out  current speed level
//   period     out  current tick period in vga_clk cycles
//   at_max     out  high when level == MAX_LEVEL
//   tick_cnt   out  ticks since reset/restart, wraps modulo 2^TCNT_W
module snake_tick_gen #(
  parameter int BASE_PERIOD = 25_000_000,
  parameter int STEP        = 2_500_000,
  parameter int MIN_PERIOD  = 2_500_000,
  parameter int MAX_LEVEL   = 15,
  parameter int CNT_W       = 25,
  parameter int LVL_W       = 4,
  parameter int TCNT_W      = 16
) (
  input  logic              vga_clk,
  input  logic              sys_rst,
  input  logic              en,
  input  logic              restart,
  input  logic              level_up,
  output logic              tick,
  output logic              half_tick,
  output logic [LVL_W-1:0]  level,
  output logic [CNT_W-1:0]  period,
  output logic              at_max,
  output logic [TCNT_W-1:0] tick_cnt
);

  localparam logic [CNT_W-1:0]  BASE_C     = CNT_W'(BASE_PERIOD);
  localparam logic [CNT_W-1:0]  STEP_C     = CNT_W'(STEP);
  localparam logic [CNT_W-1:0]  MIN_C      = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_ONE_C  = CNT_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ONE_C  = LVL_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_ONE_C = TCNT_W'(1);
  localparam logic [LVL_W-1:0]  MAX_LVL_C  = LVL_W'(MAX_LEVEL);
  localparam logic              AT_MAX_RST_C = (MAX_LEVEL == 0);
  // Subtracting STEP keeps the period at or above MIN_PERIOD exactly when the
  // current period is at least MIN_PERIOD + STEP. One extra bit so the sum
  // cannot wrap for periods near the top of the counter range.
  localparam logic [CNT_W:0]    SHRINK_FLOOR_C = (CNT_W+1)'(MIN_PERIOD + STEP);

  logic [CNT_W-1:0]  cnt_reg,      cnt_next;
  logic [CNT_W-1:0]  period_reg,   period_next;
  logic [LVL_W-1:0]  level_reg,    level_next;
  logic              tick_reg,     tick_next;
  logic              half_reg,     half_next;
  logic              at_max_reg,   at_max_next;
  logic [TCNT_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [CNT_W-1:0]  half_mark;
  logic              terminal;

  // period >= 2, so neither subtraction can underflow.
  assign half_mark = (period_reg >> 1) - CNT_ONE_C;
  // ">=" rather than "==" so a period that shrinks below the running count
  // ends the interval on the next enabled edge instead of wrapping the counter.
  assign terminal  = (cnt_reg >= period_reg - CNT_ONE_C);

  always_comb begin
    cnt_next      = cnt_reg;
    period_next   = period_reg;
    level_next    = level_reg;
    tick_next     = 1'b0;
    half_next     = 1'b0;
    at_max_next   = at_max_reg;
    tick_cnt_next = tick_cnt_reg;

    // The terminal compare uses the period in force before any level_up on
    // this edge, so a coincident level_up only affects the next interval.
    if (en) begin
      half_next = (cnt_reg == half_mark);
      if (terminal) begin
        cnt_next      = '0;
        tick_next     = 1'b1;
        tick_cnt_next = tick_cnt_reg + TCNT_ONE_C;
      end else begin
        cnt_next = cnt_reg + CNT_ONE_C;
      end
    end

    // Speed changes are accepted while paused as well.
    if (level_up && (level_reg < MAX_LVL_C)) begin
      level_next = level_reg + LVL_ONE_C;
      if ({1'b0, period_reg} >= SHRINK_FLOOR_C) begin
        period_next = period_reg - STEP_C;
      end else begin
        period_next = MIN_C;
      end
      at_max_next = (level_next == MAX_LVL_C);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst || restart) begin
      cnt_reg      <= '0;
      period_reg   <= BASE_C;
      level_reg    <= '0;
      tick_reg     <= 1'b0;
      half_reg     <= 1'b0;
      at_max_reg   <= AT_MAX_RST_C;
      tick_cnt_reg <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      period_reg   <= period_next;
      level_reg    <= level_next;
      tick_reg     <= tick_next;
      half_reg     <= half_next;
      at_max_reg   <= at_max_next;
      tick_cnt_reg <= tick_cnt_next;
    end
  end

  assign tick      = tick_reg;
  assign half_tick = half_reg;
  assign level     = level_reg;
  assign period    = period_reg;
  assign at_max    = at_max_reg;
  assign tick_cnt  = tick_cnt_reg;

endmodule

// File: tb/tb_snake_tick_gen.sv
module tb_snake_tick_gen;

  localparam int BASE   = 10;
  localparam int STEP   = 3;
  localparam int MINP   = 4;
  localparam int MAXL   = 3;
  localparam int CNT_W  = 8;
  localparam int LVL_W  = 4;
  localparam int TCNT_W = 4;

  logic              vga_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              en = 1'b0;
  logic              restart = 1'b0;
  logic              level_up = 1'b0;
  logic              tick;
  logic              half_tick;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  period;
  logic              at_max;
  logic [TCNT_W-1:0] tick_cnt;

  always #5 vga_clk = ~vga_clk;

  snake_tick_gen #(
    .BASE_PERIOD(BASE), .STEP(STEP), .MIN_PERIOD(MINP), .MAX_LEVEL(MAXL),
    .CNT_W(CNT_W), .LVL_W(LVL_W), .TCNT_W(TCNT_W)
  ) dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .en(en), .restart(restart),
    .level_up(level_up), .tick(tick), .half_tick(half_tick), .level(level),
    .period(period), .at_max(at_max), .tick_cnt(tick_cnt)
  );

  typedef struct {
    logic              tick;
    logic              half;
    logic [LVL_W-1:0]  level;
    logic [CNT_W-1:0]  period;
    logic              at_max;
    logic [TCNT_W-1:0] tcnt;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // Behavioural reference, written from the tick-generator description.
  int   m_cnt, m_period, m_level, m_tcnt;
  logic m_tick, m_half, m_at_max;

  task automatic model_edge(input logic e, input logic r, input logic lu, input logic rs);
    logic nt, nh;
    if (rs || r) begin
      m_cnt = 0; m_period = BASE; m_level = 0; m_tcnt = 0;
      m_tick = 1'b0; m_half = 1'b0; m_at_max = 1'b0;
    end else begin
      nt = 1'b0;
      nh = 1'b0;
      if (e) begin
        nh = (m_cnt == m_period / 2 - 1);
        if (m_cnt >= m_period - 1) begin
          m_cnt  = 0;
          nt     = 1'b1;
          m_tcnt = (m_tcnt + 1) % 16;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      if (lu && m_level < MAXL) begin
        m_level  = m_level + 1;
        m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
        m_at_max = (m_level == MAXL);
      end
      m_tick = nt;
      m_half = nh;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle, push the model's prediction, then compare after the edge.
  task automatic cycle(input logic e, input logic r, input logic lu, input logic rs);
    exp_t x;
    en = e; restart = r; level_up = lu; sys_rst = rs;
    model_edge(e, r, lu, rs);
    x.tick   = m_tick;
    x.half   = m_half;
    x.level  = LVL_W'(m_level);
    x.period = CNT_W'(m_period);
    x.at_max = m_at_max;
    x.tcnt   = TCNT_W'(m_tcnt);
    sb_q.push_back(x);
    @(posedge vga_clk);
    #1;
    cyc++;
    x = sb_q.pop_front();
    checks++;
    if (tick !== x.tick || half_tick !== x.half || level !== x.level ||
        period !== x.period || at_max !== x.at_max || tick_cnt !== x.tcnt) begin
      errors++;
      $display("FAIL scoreboard cycle %0d: got tick=%b half=%b level=%0d period=%0d at_max=%b tcnt=%0d, expected tick=%b half=%b level=%0d period=%0d at_max=%b tcnt=%0d",
               cyc, tick, half_tick, level, period, at_max, tick_cnt,
               x.tick, x.half, x.level, x.period, x.at_max, x.tcnt);
    end
  endtask

  task automatic run_to_tick(input int bound, output int n);
    n = 0;
    do begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n++;
    end while (tick !== 1'b1 && n < bound);
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no tick within %0d cycles (cycle %0d)", bound, cyc);
    end
  endtask

  typedef struct {
    logic e, r, lu;
    int   n;
    int   exp_level, exp_period;
    logic exp_at_max;
    int   exp_tcnt;
  } vec_t;

  initial begin
    vec_t vt[7];
    int   tick_at[$];
    int   half_at[$];
    int   n, n2;

    // Level ladder while paused: 10 -> 7 -> 4 -> 4 (saturate) -> ignored -> restart.
    vt[0] = '{1'b0, 1'b0, 1'b1, 1, 1,  7, 1'b0, 3};
    vt[1] = '{1'b0, 1'b0, 1'b0, 3, 1,  7, 1'b0, 3};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1, 2,  4, 1'b0, 3};
    vt[3] = '{1'b0, 1'b0, 1'b0, 2, 2,  4, 1'b0, 3};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1, 3,  4, 1'b1, 3};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1, 3,  4, 1'b1, 3};
    vt[6] = '{1'b0, 1'b1, 1'b1, 1, 0, 10, 1'b0, 0};

    // Reset state
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_tick", 32'(tick), 0);
    check("rst_half", 32'(half_tick), 0);
    check("rst_level", 32'(level), 0);
    check("rst_period", 32'(period), 10);
    check("rst_at_max", 32'(at_max), 0);
    check("rst_tick_cnt", 32'(tick_cnt), 0);
    $display("reset: level=%0d period=%0d tick_cnt=%0d", level, period, tick_cnt);

    // Free run: ticks at 10/20/30, half ticks at 5/15/25
    for (int i = 1; i <= 30; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (tick === 1'b1) tick_at.push_back(i);
      if (half_tick === 1'b1) half_at.push_back(i);
    end
    check("run_tick_count", 32'(tick_at.size()), 3);
    check("run_half_count", 32'(half_at.size()), 3);
    for (int k = 0; k < tick_at.size() && k < 3; k++)
      check("run_tick_cycle", 32'(tick_at[k]), 32'((k + 1) * 10));
    for (int k = 0; k < half_at.size() && k < 3; k++)
      check("run_half_cycle", 32'(half_at[k]), 32'((k + 1) * 10 - 5));
    check("run_tick_cnt", 32'(tick_cnt), 3);
    $display("free run: %0d ticks, tick_cnt=%0d", tick_at.size(), tick_cnt);

    // Table-driven level ladder (paused, so tick must stay low)
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < vt[v].n; c++) cycle(vt[v].e, vt[v].r, vt[v].lu, 1'b0);
      check("vec_level", 32'(level), 32'(vt[v].exp_level));
      check("vec_period", 32'(period), 32'(vt[v].exp_period));
      check("vec_at_max", 32'(at_max), 32'(vt[v].exp_at_max));
      check("vec_tick_cnt", 32'(tick_cnt), 32'(vt[v].exp_tcnt));
      check("vec_tick", 32'(tick), 0);
      $display("vector %0d: level=%0d period=%0d at_max=%b tick_cnt=%0d", v, level, period, at_max, tick_cnt);
    end

    // level_up at cnt=8: period 10 -> 7, tick on next enabled edge, then 7 spacing
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("shrink_period", 32'(period), 7);
    check("shrink_no_tick_yet", 32'(tick), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("shrink_tick_next", 32'(tick), 1);
    run_to_tick(30, n);
    check("shrink_spacing1", 32'(n), 7);
    run_to_tick(30, n);
    check("shrink_spacing2", 32'(n), 7);
    $display("shrink mid-interval: period=%0d spacing=%0d", period, n);

    // Pause for 5 cycles at cnt=3: tick delayed by 5
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("pause_quiet", 32'({tick, half_tick}), 0);
    end
    run_to_tick(30, n);
    check("pause_spacing", 32'(3 + 5 + n), 12);
    $display("pause: tick spacing %0d", 3 + 5 + n);

    // restart at level 2, cnt 2, together with level_up
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_restart_level", 32'(level), 2);
    check("pre_restart_period", 32'(period), 4);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("restart_level", 32'(level), 0);
    check("restart_period", 32'(period), 10);
    check("restart_tick_cnt", 32'(tick_cnt), 0);
    run_to_tick(30, n);
    check("restart_spacing", 32'(n), 10);
    check("restart_first_cnt", 32'(tick_cnt), 1);
    $display("restart: next tick after %0d cycles, tick_cnt=%0d", n, tick_cnt);

    // tick_cnt wraps 15 -> 0 -> 1 over ticks 15..17
    for (int k = 2; k <= 17; k++) begin
      run_to_tick(30, n2);
      check("wrap_spacing", 32'(n2), 10);
      check("wrap_tick_cnt", 32'(tick_cnt), 32'(k % 16));
    end
    $display("wrap: tick_cnt=%0d after 17 ticks", tick_cnt);

    // sys_rst mid-interval
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    check("srst_tick", 32'(tick), 0);
    check("srst_half", 32'(half_tick), 0);
    check("srst_level", 32'(level), 0);
    check("srst_period", 32'(period), 10);
    check("srst_at_max", 32'(at_max), 0);
    check("srst_tick_cnt", 32'(tick_cnt), 0);
    run_to_tick(30, n);
    check("srst_spacing", 32'(n), 10);
    $display("sys_rst mid-interval: next tick after %0d cycles", n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
